fir_coeff_sequencer: RTL and testbench
======================================

# fir_coeff_sequencer

Upstream bus sequencer for the FIR datapath controller. It accepts a 12-tap coefficient stream and drives the controller's update flag, SRAM chip-select, write-enable, address, write-data and coefficient-index inputs through one load sequence. After loading, it issues one 10-cycle SRAM read burst per 600 kHz sample strobe. All outputs are registered and are sequenced to match the controller's Idle/SpSram/Acc/Sum transition conditions.

## Interface
- COEFF_W, 16: coefficient / write-data width (signed).
- iClk_12M  in  1  system clock, 12 MHz.
- iRsn  in  1  synchronous, active-low reset.
- iEnSample_600k  in  1  one-cycle sample strobe, nominally every 20 clocks.
- iUpdateReq  in  1  one-cycle request to (re)load coefficients.
- iCoeffValid  in  1  coefficient valid.
- iCoeffData  in  COEFF_W  coefficient value; taps arrive in order k=1..12.
- oCoeffReady  out  1  high when the sequencer can accept a coefficient.
- oCoeffiUpdateFlag  out  1  update flag to the controller.
- oCsnRam  out  1  SRAM chip select, active low.
- oWrnRam  out  1  SRAM write enable, active low.
- oAddrRam_pos  out  4  address for RAM1 (pos).
- oAddrRam_neg  out  4  address for RAM2 (neg).
- oWrDtRam  out  COEFF_W  write data.
- oNumOfCoeff  out  6  tap index k; 0 means no write.
- oLoaded  out  1  high once a full 12-tap set has been written.
- oSampleMiss  out  1  sticky flag: a sample strobe was lost.

## Operation
- State IDLE: flag=0, Csn=1, Wrn=1, num=0, addresses=0, data=0, ready=0, oLoaded=0.
  - iUpdateReq → ARM.
  - Sample strobes are ignored.
- State ENTER (1 cycle): flag=1, Csn=1, Wrn=0. Moves the controller from Sum to Idle. Next state is ARM.
- State ARM (1 cycle): flag=1, Csn=0, Wrn=0, num=0, ready=1. Next state is LOAD.
- State LOAD: flag=1, Csn=0, Wrn=0, ready = (accepted < 12).
  - A handshake (valid && ready) captures tap k. In the next cycle the block drives num=k, data=coefficient, and the address below.
  - Any cycle without a new tap drives num=0 and data=0.
  - After the 12th tap's drive cycle → HOLD, and oLoaded is cleared.
- Address map for tap k:
  - Odd k: oAddrRam_pos=(k-1)/2.
  - k=12: oAddrRam_pos=6.
  - Even k≤10: oAddrRam_neg=k/2-1.
  - The unused address is 0.
- State HOLD: flag=1, Csn=0, Wrn=0, num=0, ready=0. iEnSample_600k → RD_ARM, and oLoaded is set.
- State RD_ARM (1 cycle): flag=0, Csn=0, Wrn=1, addresses=0. Next state is READ with j=0.
- State READ (j=0..9):
  - oAddrRam_pos=j, oAddrRam_neg=min(j,8).
  - Csn=(j==9), Wrn=1, flag=0.
  - After j=9: go to ENTER if an update is pending, otherwise WAIT.
- State WAIT: flag=0, Csn=1, Wrn=1.
  - iEnSample_600k → RD_ARM.
  - iUpdateReq → ENTER.
  - If both arrive in the same cycle, the update wins and the sample is counted as missed.
- iUpdateReq during READ or RD_ARM is latched as pending and serviced after j=9.
- iUpdateReq during ENTER, ARM, LOAD or HOLD is ignored.
- iEnSample_600k during RD_ARM, READ, ENTER, ARM or LOAD is dropped and counted as missed.
- A repeat of iCoeffData after 12 taps is not accepted (ready=0).

## Timing
- Reset (iRsn=0 at a clock edge) puts the block in IDLE from any state, including mid-load or mid-burst.
  - Reset values: flag=0, Csn=1, Wrn=1, num=0, addresses=0, data=0, ready=0, oLoaded=0, oSampleMiss=0.
  - The pending-update latch and the tap counter are cleared.
- Handshake-to-write latency: a tap accepted in cycle c appears on the outputs in cycle c+1. The controller is already in SpSram at that point because ARM preceded it.
- Strobe-to-read timing: a strobe in cycle s drives RD_ARM in s+1 and READ j=0 in s+2. The controller is in Acc for exactly j=0..9 and in Sum from j=9+1.
- A burst occupies 11 cycles, which is less than the 20-cycle sample period.
- Minimum load time is ARM + 12 taps + 1 cycle.

## Configuration
- FIR_SEQ_MISS_EN defined:
  - oSampleMiss sets on any dropped strobe.
  - It is cleared by reset or by entering ARM.
- FIR_SEQ_MISS_EN undefined: oSampleMiss is tied to 0 and the miss logic is absent. The port is kept in both builds.

## Structure
- Package fir_seq_pkg holds:
  - the state enum;
  - NUM_TAPS=12, READ_LEN=10, NEG_LAST=8;
  - the tap-index width (6).
- Sub-module fir_seq_addr_map: combinational map from tap index to {ram_sel, addr_pos, addr_neg}. It is instantiated once.

## Test plan
- Reset, update request, then 12 back-to-back taps with values 0x0101..0x010C.
  - Expect ARM, then num=1..12 on consecutive cycles.
  - Tap 12 drives addr_pos=6; tap 10 drives addr_neg=4.
  - Expect HOLD afterwards with ready=0.
- Taps with valid toggled every other cycle.
  - Expect num=0 in every gap cycle.
  - Expect each tap to be written exactly once, with correct data.
- Loaded block, strobe every 20 cycles.
  - Expect RD_ARM at s+1, then addr_pos 0..9 and addr_neg 0..8,8.
  - Expect Csn=1 only at j=9, followed by WAIT.
- Update request at READ j=3.
  - Expect the burst to complete, then ENTER (flag=1, Csn=1, Wrn=0), then ARM, then LOAD.
- Strobe during LOAD, and strobe coinciding with an update request in WAIT.
  - With FIR_SEQ_MISS_EN defined, expect oSampleMiss=1; without it, expect 0.
- iRsn low at tap 5 and again at READ j=4.
  - Expect all reset values on the next cycle.
  - Expect a new update request to restart cleanly from tap 1.

Source files
------------

// File: rtl/fir_seq_pkg.sv
// Shared constants and state encoding for the FIR coefficient sequencer.
package fir_seq_pkg;
   localparam int NUM_TAPS = 12;
   localparam int READ_LEN = 10;
   localparam int NEG_LAST = 8;
   localparam int TAP_W    = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTER,
      S_ARM,
      S_LOAD,
      S_HOLD,
      S_RD_ARM,
      S_READ,
      S_WAIT
   } seqState_t;
endpackage

// File: rtl/fir_seq_addr_map.sv
// Tap index to SRAM address map: odd taps and tap 12 go to RAM1 (pos),
// even taps up to 10 go to RAM2 (neg). Index 0 maps to nothing.
module fir_seq_addr_map
   import fir_seq_pkg::*;
(
   input  logic [TAP_W-1:0] tapIdx,
   output logic             ramSel,
   output logic [3:0]       addrPos,
   output logic [3:0]       addrNeg
);
   always_comb begin
      ramSel  = !tapIdx[0] && (tapIdx != '0) && (tapIdx <= TAP_W'(NUM_TAPS - 2));
      // (k-1)/2 for odd k and 12/2 = 6 for the last tap share one shift
      addrPos = ramSel ? 4'd0 : 4'(tapIdx >> 1);
      addrNeg = ramSel ? 4'((tapIdx >> 1) - TAP_W'(1)) : 4'd0;
   end
endmodule

// File: rtl/fir_coeff_sequencer.sv
// Bus sequencer driving the FIR controller through coefficient load and
// per-sample SRAM read bursts. Define FIR_SEQ_MISS_EN for the sticky miss flag.
module fir_coeff_sequencer
   import fir_seq_pkg::*;
#(
   parameter int COEFF_W = 16
) (
   input  logic               iClk_12M,
   input  logic               iRsn,
   input  logic               iEnSample_600k,
   input  logic               iUpdateReq,
   input  logic               iCoeffValid,
   input  logic [COEFF_W-1:0] iCoeffData,
   output logic               oCoeffReady,
   output logic               oCoeffiUpdateFlag,
   output logic               oCsnRam,
   output logic               oWrnRam,
   output logic [3:0]         oAddrRam_pos,
   output logic [3:0]         oAddrRam_neg,
   output logic [COEFF_W-1:0] oWrDtRam,
   output logic [TAP_W-1:0]   oNumOfCoeff,
   output logic               oLoaded,
   output logic               oSampleMiss
);
   seqState_t          state, nextState;
   logic [3:0]         cnt, cntNext;
   logic [3:0]         rdIdx, rdNext;
   logic               pending, pendNext;
   logic               loadedNext;
   logic               flagN, csnN, wrnN, readyN;
   logic [3:0]         posN, negN;
   logic [COEFF_W-1:0] dataN;
   logic [TAP_W-1:0]   numN;

   logic               handshake;
   logic [TAP_W-1:0]   tapIdx;
   logic               mapSel;
   logic [3:0]         mapPos, mapNeg;

   assign handshake = iCoeffValid && oCoeffReady && (state == S_ARM || state == S_LOAD);
   assign tapIdx    = handshake ? TAP_W'(cnt) + TAP_W'(1) : '0;

   fir_seq_addr_map uAddrMap (
      .tapIdx  (tapIdx),
      .ramSel  (mapSel),
      .addrPos (mapPos),
      .addrNeg (mapNeg)
   );

   always_comb begin
      nextState  = state;
      cntNext    = cnt;
      rdNext     = rdIdx;
      pendNext   = pending;
      loadedNext = oLoaded;
      flagN      = 1'b0;
      csnN       = 1'b1;
      wrnN       = 1'b1;
      readyN     = 1'b0;
      posN       = 4'd0;
      negN       = 4'd0;
      dataN      = '0;
      numN       = '0;

      case (state)
         S_IDLE:   if (iUpdateReq) nextState = S_ARM;
         S_ENTER:  nextState = S_ARM;
         S_ARM:    nextState = S_LOAD;
         S_LOAD:   if (oNumOfCoeff == TAP_W'(NUM_TAPS)) begin
                      nextState  = S_HOLD;
                      loadedNext = 1'b0;
                   end
         S_HOLD:   if (iEnSample_600k) begin
                      nextState  = S_RD_ARM;
                      loadedNext = 1'b1;
                   end
         S_RD_ARM: begin
                      nextState = S_READ;
                      rdNext    = 4'd0;
                   end
         S_READ:   if (rdIdx == 4'(READ_LEN - 1))
                      nextState = (pending || iUpdateReq) ? S_ENTER : S_WAIT;
                   else
                      rdNext = rdIdx + 4'd1;
         S_WAIT:   if (iUpdateReq)          nextState = S_ENTER;
                   else if (iEnSample_600k) nextState = S_RD_ARM;
         default:  nextState = S_IDLE;
      endcase

      if (handshake) cntNext = cnt + 4'd1;

      if (nextState == S_ENTER)
         pendNext = 1'b0;
      else if (iUpdateReq && (state == S_RD_ARM || state == S_READ))
         pendNext = 1'b1;

      // outputs are decoded from the upcoming state so they land registered
      case (nextState)
         S_ENTER: begin
            flagN = 1'b1;
            wrnN  = 1'b0;
         end
         S_ARM: begin
            flagN   = 1'b1;
            csnN    = 1'b0;
            wrnN    = 1'b0;
            readyN  = 1'b1;
            cntNext = 4'd0;
         end
         S_LOAD: begin
            flagN  = 1'b1;
            csnN   = 1'b0;
            wrnN   = 1'b0;
            readyN = (cntNext < 4'(NUM_TAPS));
            if (handshake) begin
               numN  = tapIdx;
               dataN = iCoeffData;
               posN  = mapSel ? 4'd0 : mapPos;
               negN  = mapSel ? mapNeg : 4'd0;
            end
         end
         S_HOLD: begin
            flagN = 1'b1;
            csnN  = 1'b0;
            wrnN  = 1'b0;
         end
         S_RD_ARM: csnN = 1'b0;
         S_READ: begin
            csnN = (rdNext == 4'(READ_LEN - 1));
            posN = rdNext;
            negN = (rdNext > 4'(NEG_LAST)) ? 4'(NEG_LAST) : rdNext;
         end
         default: ;
      endcase
   end

   always_ff @(posedge iClk_12M) begin
      if (!iRsn) begin
         state             <= S_IDLE;
         cnt               <= '0;
         rdIdx             <= '0;
         pending           <= 1'b0;
         oLoaded           <= 1'b0;
         oCoeffiUpdateFlag <= 1'b0;
         oCsnRam           <= 1'b1;
         oWrnRam           <= 1'b1;
         oCoeffReady       <= 1'b0;
         oAddrRam_pos      <= '0;
         oAddrRam_neg      <= '0;
         oWrDtRam          <= '0;
         oNumOfCoeff       <= '0;
      end else begin
         state             <= nextState;
         cnt               <= cntNext;
         rdIdx             <= rdNext;
         pending           <= pendNext;
         oLoaded           <= loadedNext;
         oCoeffiUpdateFlag <= flagN;
         oCsnRam           <= csnN;
         oWrnRam           <= wrnN;
         oCoeffReady       <= readyN;
         oAddrRam_pos      <= posN;
         oAddrRam_neg      <= negN;
         oWrDtRam          <= dataN;
         oNumOfCoeff       <= numN;
      end
   end

`ifdef FIR_SEQ_MISS_EN
   logic missEvt;

   always_comb begin
      missEvt = 1'b0;
      if (iEnSample_600k) begin
         case (state)
            S_RD_ARM, S_READ, S_ENTER, S_ARM, S_LOAD: missEvt = 1'b1;
            S_WAIT:  missEvt = iUpdateReq;
            default: missEvt = 1'b0;
         endcase
      end
   end

   // a strobe dropped on the way into ARM still wins over the clear
   always_ff @(posedge iClk_12M) begin
      if (!iRsn)                   oSampleMiss <= 1'b0;
      else if (missEvt)            oSampleMiss <= 1'b1;
      else if (nextState == S_ARM) oSampleMiss <= 1'b0;
   end
`else
   assign oSampleMiss = 1'b0;
`endif
endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Directed self-checking bench for fir_coeff_sequencer (either FIR_SEQ_MISS_EN build).
module tb_fir_coeff_sequencer;
   localparam int COEFF_W = 16;
`ifdef FIR_SEQ_MISS_EN
   localparam logic MISS_EXP = 1'b1;
`else
   localparam logic MISS_EXP = 1'b0;
`endif

   logic               iClk_12M = 1'b0;
   logic               iRsn = 1'b0;
   logic               iEnSample_600k = 1'b0;
   logic               iUpdateReq = 1'b0;
   logic               iCoeffValid = 1'b0;
   logic [COEFF_W-1:0] iCoeffData = '0;
   logic               oCoeffReady, oCoeffiUpdateFlag, oCsnRam, oWrnRam, oLoaded, oSampleMiss;
   logic [3:0]         oAddrRam_pos, oAddrRam_neg;
   logic [COEFF_W-1:0] oWrDtRam;
   logic [5:0]         oNumOfCoeff;

   int nChecks = 0;
   int nFail   = 0;

   wire [3:0] ctl = {oCoeffiUpdateFlag, oCsnRam, oWrnRam, oCoeffReady};

   fir_coeff_sequencer #(.COEFF_W(COEFF_W)) dut (
      .iClk_12M          (iClk_12M),
      .iRsn              (iRsn),
      .iEnSample_600k    (iEnSample_600k),
      .iUpdateReq        (iUpdateReq),
      .iCoeffValid       (iCoeffValid),
      .iCoeffData        (iCoeffData),
      .oCoeffReady       (oCoeffReady),
      .oCoeffiUpdateFlag (oCoeffiUpdateFlag),
      .oCsnRam           (oCsnRam),
      .oWrnRam           (oWrnRam),
      .oAddrRam_pos      (oAddrRam_pos),
      .oAddrRam_neg      (oAddrRam_neg),
      .oWrDtRam          (oWrDtRam),
      .oNumOfCoeff       (oNumOfCoeff),
      .oLoaded           (oLoaded),
      .oSampleMiss       (oSampleMiss)
   );

   always #5 iClk_12M = ~iClk_12M;

   task automatic tick();
      @(posedge iClk_12M);
      #1;
   endtask

   function automatic logic [3:0] expPos(int k);
      if (k == 12) return 4'd6;
      if (k % 2 == 1) return 4'((k - 1) / 2);
      return 4'd0;
   endfunction

   function automatic logic [3:0] expNeg(int k);
      if (k % 2 == 0 && k <= 10) return 4'(k / 2 - 1);
      return 4'd0;
   endfunction

   // stimulus: from a ready cycle, stream taps first..12 then fall into HOLD
   task automatic drive_taps(int first, logic [15:0] base);
      for (int k = first; k <= 12; k++) begin
         iCoeffValid = 1'b1;
         iCoeffData  = base + 16'(k);
         tick();
      end
      iCoeffValid = 1'b0;
      tick();
   endtask

   // stimulus: strobe then run through a whole burst into WAIT
   task automatic run_burst();
      iEnSample_600k = 1'b1;
      tick();
      iEnSample_600k = 1'b0;
      for (int i = 0; i < 11; i++) tick();
   endtask

   task automatic test_reset();
      iRsn = 1'b0;
      tick();
      iRsn = 1'b1;
      nChecks++; if (ctl !== 4'b0110) begin nFail++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 4'b0110); end
      nChecks++; if ({oNumOfCoeff, oAddrRam_pos, oAddrRam_neg, oWrDtRam} !== '0) begin nFail++;
         $display("FAIL reset_bus got num=%0d pos=%0d neg=%0d data=%h exp all 0", oNumOfCoeff, oAddrRam_pos, oAddrRam_neg, oWrDtRam); end
      nChecks++; if ({oLoaded, oSampleMiss} !== 2'b00) begin nFail++; $display("FAIL reset_flags got=%b exp=00", {oLoaded, oSampleMiss}); end
      // strobes in IDLE are ignored
      iEnSample_600k = 1'b1;
      tick();
      iEnSample_600k = 1'b0;
      nChecks++; if ({ctl, oSampleMiss} !== 5'b01100) begin nFail++; $display("FAIL idle_strobe got=%b exp=%b", {ctl, oSampleMiss}, 5'b01100); end
   endtask

   task automatic test_back_to_back();
      iUpdateReq = 1'b1;
      tick();
      iUpdateReq = 1'b0;
      nChecks++; if (ctl !== 4'b1001 || oNumOfCoeff !== 6'd0) begin nFail++; $display("FAIL arm got ctl=%b num=%0d exp ctl=1001 num=0", ctl, oNumOfCoeff); end
      for (int k = 1; k <= 12; k++) begin
         iCoeffValid = 1'b1;
         iCoeffData  = 16'h0100 + 16'(k);
         tick();
         nChecks++; if (oNumOfCoeff !== 6'(k) || oWrDtRam !== 16'h0100 + 16'(k)) begin nFail++;
            $display("FAIL b2b_tap%0d got num=%0d data=%h exp num=%0d data=%h", k, oNumOfCoeff, oWrDtRam, k, 16'h0100 + 16'(k)); end
         nChecks++; if (oAddrRam_pos !== expPos(k) || oAddrRam_neg !== expNeg(k)) begin nFail++;
            $display("FAIL b2b_addr%0d got pos=%0d neg=%0d exp pos=%0d neg=%0d", k, oAddrRam_pos, oAddrRam_neg, expPos(k), expNeg(k)); end
         nChecks++; if (ctl !== ((k == 12) ? 4'b1000 : 4'b1001)) begin nFail++;
            $display("FAIL b2b_ctl%0d got=%b exp=%b", k, ctl, (k == 12) ? 4'b1000 : 4'b1001); end
      end
      // extra tap offered after the set is complete must be refused
      iCoeffData = 16'h0BAD;
      tick();
      iCoeffValid = 1'b0;
      nChecks++; if (ctl !== 4'b1000 || oNumOfCoeff !== 6'd0 || oWrDtRam !== 16'h0) begin nFail++;
         $display("FAIL hold got ctl=%b num=%0d data=%h exp ctl=1000 num=0 data=0000", ctl, oNumOfCoeff, oWrDtRam); end
      nChecks++; if (oLoaded !== 1'b0) begin nFail++; $display("FAIL hold_loaded got=%b exp=0", oLoaded); end
      // updates are ignored in HOLD
      iUpdateReq = 1'b1;
      tick();
      iUpdateReq = 1'b0;
      nChecks++; if (ctl !== 4'b1000) begin nFail++; $display("FAIL hold_upd got=%b exp=1000", ctl); end
   endtask

   task automatic test_toggle_valid();
      logic [12:0] seen;
      int          writes;
      seen   = '0;
      writes = 0;
      iUpdateReq = 1'b1;
      tick();
      iUpdateReq = 1'b0;
      for (int i = 0; i < 24; i++) begin
         iCoeffValid = (i % 2 == 0);
         iCoeffData  = 16'h0200 + 16'(i / 2 + 1);
         tick();
         if (oNumOfCoeff != 6'd0) begin
            writes++;
            seen[oNumOfCoeff[3:0]] = 1'b1;
         end
         if (i % 2 == 0) begin
            nChecks++; if (oNumOfCoeff !== 6'(i / 2 + 1) || oWrDtRam !== 16'h0200 + 16'(i / 2 + 1)) begin nFail++;
               $display("FAIL tog_tap%0d got num=%0d data=%h exp num=%0d data=%h", i / 2 + 1, oNumOfCoeff, oWrDtRam, i / 2 + 1, 16'h0200 + 16'(i / 2 + 1)); end
         end else begin
            nChecks++; if (oNumOfCoeff !== 6'd0 || oWrDtRam !== 16'h0) begin nFail++;
               $display("FAIL tog_gap%0d got num=%0d data=%h exp num=0 data=0000", i, oNumOfCoeff, oWrDtRam); end
         end
      end
      iCoeffValid = 1'b0;
      nChecks++; if (writes !== 12 || seen !== 13'h1FFE) begin nFail++; $display("FAIL tog_once got writes=%0d seen=%h exp 12/1ffe", writes, seen); end
      nChecks++; if (ctl !== 4'b1000) begin nFail++; $display("FAIL tog_hold got=%b exp=1000", ctl); end
   endtask

   task automatic test_read();
      for (int b = 0; b < 2; b++) begin
         iEnSample_600k = 1'b1;
         tick();
         iEnSample_600k = 1'b0;
         nChecks++; if (ctl !== 4'b0010 || oAddrRam_pos !== 4'd0 || oAddrRam_neg !== 4'd0 || oLoaded !== 1'b1) begin nFail++;
            $display("FAIL rdarm%0d got ctl=%b pos=%0d neg=%0d loaded=%b exp 0010/0/0/1", b, ctl, oAddrRam_pos, oAddrRam_neg, oLoaded); end
         for (int j = 0; j < 10; j++) begin
            tick();
            nChecks++;
            if (oAddrRam_pos !== 4'(j) || oAddrRam_neg !== 4'((j > 8) ? 8 : j) || ctl !== {1'b0, j == 9, 2'b10}) begin nFail++;
               $display("FAIL read%0d_j%0d got pos=%0d neg=%0d ctl=%b exp pos=%0d neg=%0d ctl=%b", b, j, oAddrRam_pos, oAddrRam_neg, ctl,
                        j, (j > 8) ? 8 : j, {1'b0, j == 9, 2'b10}); end
         end
         tick();
         nChecks++; if (ctl !== 4'b0110 || oAddrRam_pos !== 4'd0) begin nFail++; $display("FAIL wait%0d got ctl=%b pos=%0d exp 0110/0", b, ctl, oAddrRam_pos); end
         if (b == 0) for (int i = 0; i < 8; i++) tick();
      end
   endtask

   task automatic test_update_mid_read();
      iEnSample_600k = 1'b1;
      tick();
      iEnSample_600k = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      nChecks++; if (oAddrRam_pos !== 4'd3) begin nFail++; $display("FAIL upd_j3 got pos=%0d exp 3", oAddrRam_pos); end
      iUpdateReq = 1'b1;
      tick();
      iUpdateReq = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      nChecks++; if (oAddrRam_pos !== 4'd9 || ctl !== 4'b0110) begin nFail++; $display("FAIL upd_j9 got pos=%0d ctl=%b exp 9/0110", oAddrRam_pos, ctl); end
      tick();
      nChecks++; if (ctl !== 4'b1100) begin nFail++; $display("FAIL upd_enter got=%b exp=1100", ctl); end
      tick();
      nChecks++; if (ctl !== 4'b1001 || oNumOfCoeff !== 6'd0) begin nFail++; $display("FAIL upd_arm got ctl=%b num=%0d exp 1001/0", ctl, oNumOfCoeff); end
      tick();
      nChecks++; if (ctl !== 4'b1001 || oNumOfCoeff !== 6'd0) begin nFail++; $display("FAIL upd_load got ctl=%b num=%0d exp 1001/0", ctl, oNumOfCoeff); end
   endtask

   task automatic test_miss();
      drive_taps(1, 16'h0400);
      run_burst();
      nChecks++; if (oSampleMiss !== 1'b0 || ctl !== 4'b0110) begin nFail++; $display("FAIL miss_pre got miss=%b ctl=%b exp 0/0110", oSampleMiss, ctl); end
      iEnSample_600k = 1'b1;
      iUpdateReq     = 1'b1;
      tick();
      iEnSample_600k = 1'b0;
      iUpdateReq     = 1'b0;
      nChecks++; if (ctl !== 4'b1100 || oSampleMiss !== MISS_EXP) begin nFail++; $display("FAIL miss_coinc got ctl=%b miss=%b exp 1100/%b", ctl, oSampleMiss, MISS_EXP); end
      tick();
      nChecks++; if (ctl !== 4'b1001 || oSampleMiss !== 1'b0) begin nFail++; $display("FAIL miss_arm_clr got ctl=%b miss=%b exp 1001/0", ctl, oSampleMiss); end
      tick();
      iEnSample_600k = 1'b1;
      tick();
      iEnSample_600k = 1'b0;
      nChecks++; if (oSampleMiss !== MISS_EXP || ctl !== 4'b1001) begin nFail++; $display("FAIL miss_load got miss=%b ctl=%b exp %b/1001", oSampleMiss, ctl, MISS_EXP); end
   endtask

   task automatic test_reset_mid();
      iRsn = 1'b0;
      tick();
      iRsn = 1'b1;
      iUpdateReq = 1'b1;
      tick();
      iUpdateReq = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         iCoeffValid = 1'b1;
         iCoeffData  = 16'h0300 + 16'(k);
         tick();
      end
      iCoeffData = 16'h0305;
      iRsn       = 1'b0;
      tick();
      iRsn        = 1'b1;
      iCoeffValid = 1'b0;
      nChecks++; if ({ctl, oNumOfCoeff, oAddrRam_pos, oAddrRam_neg, oWrDtRam, oLoaded, oSampleMiss} !== {4'b0110, 6'd0, 8'd0, 16'h0, 2'b00}) begin nFail++;
         $display("FAIL rst_tap5 got ctl=%b num=%0d pos=%0d neg=%0d data=%h loaded=%b miss=%b", ctl, oNumOfCoeff, oAddrRam_pos, oAddrRam_neg, oWrDtRam, oLoaded, oSampleMiss); end
      iUpdateReq = 1'b1;
      tick();
      iUpdateReq  = 1'b0;
      iCoeffValid = 1'b1;
      iCoeffData  = 16'h0311;
      tick();
      nChecks++; if (oNumOfCoeff !== 6'd1 || oWrDtRam !== 16'h0311 || oAddrRam_pos !== 4'd0) begin nFail++;
         $display("FAIL rst_restart1 got num=%0d data=%h pos=%0d exp 1/0311/0", oNumOfCoeff, oWrDtRam, oAddrRam_pos); end
      drive_taps(2, 16'h0310);
      iEnSample_600k = 1'b1;
      tick();
      iEnSample_600k = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      nChecks++; if (oAddrRam_pos !== 4'd4 || oLoaded !== 1'b1) begin nFail++; $display("FAIL rst_j4 got pos=%0d loaded=%b exp 4/1", oAddrRam_pos, oLoaded); end
      iRsn = 1'b0;
      tick();
      iRsn = 1'b1;
      nChecks++; if ({ctl, oNumOfCoeff, oAddrRam_pos, oAddrRam_neg, oWrDtRam, oLoaded, oSampleMiss} !== {4'b0110, 6'd0, 8'd0, 16'h0, 2'b00}) begin nFail++;
         $display("FAIL rst_read got ctl=%b num=%0d pos=%0d neg=%0d data=%h loaded=%b miss=%b", ctl, oNumOfCoeff, oAddrRam_pos, oAddrRam_neg, oWrDtRam, oLoaded, oSampleMiss); end
      iUpdateReq = 1'b1;
      tick();
      iUpdateReq  = 1'b0;
      iCoeffValid = 1'b1;
      iCoeffData  = 16'h0321;
      tick();
      iCoeffValid = 1'b0;
      nChecks++; if (oNumOfCoeff !== 6'd1 || oWrDtRam !== 16'h0321) begin nFail++;
         $display("FAIL rst_restart2 got num=%0d data=%h exp 1/0321", oNumOfCoeff, oWrDtRam); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_read();
      test_update_mid_read();
      test_miss();
      test_toggle_valid();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
      $finish;
   end
endmodule
